// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC and drives the instruction memory address.
// It also holds the IF/ID pipeline register and a saturating count of fetched instructions.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0064,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      pc_out,
    input  logic [31:0]      inst_in,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      ifid_inst,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] fetch_count
);

    logic [31:0]      r_pc;
    logic [31:0]      r_ifid_inst;
    logic [31:0]      r_ifid_pc4;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_fetch_count;

    logic [31:0]      w_pc4;
    logic [31:0]      w_redirect_target;
    logic             w_advance;
    logic             w_bubble;
    logic             w_load;
    logic             w_count_sat;

    logic [31:0]      w_pc_next;
    logic [31:0]      w_ifid_inst_next;
    logic [31:0]      w_ifid_pc4_next;
    logic             w_ifid_valid_next;
    logic [CNT_W-1:0] w_fetch_count_next;

    // Wraps modulo 2^32, so 32'hFFFF_FFFC advances to zero.
    assign w_pc4             = r_pc + 32'd4;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign w_advance         = !redirect_en && !stall;
    // Redirect squashes the wrong-path fetch; flush inserts a bubble even while stalled.
    assign w_bubble          = redirect_en || flush;
    assign w_load            = w_advance && !flush;
    assign w_count_sat       = &r_fetch_count;

    always_comb begin
        w_pc_next = r_pc;
        if (redirect_en) begin
            w_pc_next = w_redirect_target;
        end else if (!stall) begin
            w_pc_next = w_pc4;
        end
    end

    always_comb begin
        w_ifid_inst_next  = r_ifid_inst;
        w_ifid_pc4_next   = r_ifid_pc4;
        w_ifid_valid_next = r_ifid_valid;
        if (w_bubble) begin
            w_ifid_inst_next  = NOP_WORD;
            w_ifid_pc4_next   = 32'd0;
            w_ifid_valid_next = 1'b0;
        end else if (w_load) begin
            w_ifid_inst_next  = inst_in;
            w_ifid_pc4_next   = w_pc4;
            w_ifid_valid_next = 1'b1;
        end
    end

    always_comb begin
        w_fetch_count_next = r_fetch_count;
        if (w_load && !w_count_sat) begin
            w_fetch_count_next = r_fetch_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_ifid_inst   <= NOP_WORD;
            r_ifid_pc4    <= 32'd0;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_ifid_inst   <= w_ifid_inst_next;
            r_ifid_pc4    <= w_ifid_pc4_next;
            r_ifid_valid  <= w_ifid_valid_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    assign pc_out      = r_pc;
    assign ifid_inst   = r_ifid_inst;
    assign ifid_pc4    = r_ifid_pc4;
    assign ifid_valid  = r_ifid_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// and random traffic checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] inst_in;

    logic [31:0] pc_a, inst_a, pc4_a;
    logic        valid_a;
    logic [15:0] cnt_a;
    logic [31:0] pc_b, inst_b, pc4_b;
    logic        valid_b;
    logic [3:0]  cnt_b;

    logic [31:0] mem [256];

    int checks   = 0;
    int failures = 0;

    fetch_stage dut_a (
        .clk(clk), .rst(rst), .pc_out(pc_a), .inst_in(inst_in),
        .stall(stall), .flush(flush), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .ifid_inst(inst_a), .ifid_pc4(pc4_a),
        .ifid_valid(valid_a), .fetch_count(cnt_a)
    );

    fetch_stage #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .pc_out(pc_b), .inst_in(inst_in),
        .stall(stall), .flush(flush), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .ifid_inst(inst_b), .ifid_pc4(pc4_b),
        .ifid_valid(valid_b), .fetch_count(cnt_b)
    );

    // Combinational instruction memory, word-indexed by the PC
    assign inst_in = mem[pc_a[9:2]];

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic        e_valid;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid;
    int          m_cnt;

    function automatic logic [31:0] mem_val(int idx);
        if (idx == 25) return 32'h8C02_0000;
        if (idx == 26) return 32'h8C03_0004;
        return 32'hC0DE_0000 | idx;
    endfunction

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic add(string name, logic r, logic s, logic f, logic rd, logic [31:0] rpc,
                       logic [31:0] e_pc, logic [31:0] e_inst, logic [31:0] e_pc4,
                       logic e_valid, int e_cnt);
        vec_t v;
        v.name = name; v.rst = r; v.stall = s; v.flush = f; v.redir = rd; v.rpc = rpc;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // driver: inputs change #1 after the edge, outputs sampled #1 after the next edge
    task automatic drive(logic r, logic s, logic f, logic rd, logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect_en = rd; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, logic [31:0] e_pc, logic [31:0] e_inst,
                           logic [31:0] e_pc4, logic e_valid, int e_cnt);
        chk({tag, ".pc"},     pc_a, e_pc);
        chk({tag, ".inst"},   inst_a, e_inst);
        chk({tag, ".pc4"},    pc4_a, e_pc4);
        chk({tag, ".valid"},  {31'd0, valid_a}, {31'd0, e_valid});
        chk({tag, ".cnt16"},  {16'd0, cnt_a}, sat(e_cnt, 65535));
        chk({tag, ".pc_w4"},  pc_b, e_pc);
        chk({tag, ".cnt4"},   {28'd0, cnt_b}, sat(e_cnt, 15));
    endtask

    // Behavioural model: one clock edge of the fetch rules
    task automatic model_step(logic r, logic s, logic f, logic rd, logic [31:0] rpc);
        if (r) begin
            m_pc = 32'h64; m_inst = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        end else if (rd) begin
            m_pc = rpc & 32'hFFFF_FFFC; m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (s) begin
            if (f) begin m_inst = 0; m_pc4 = 0; m_valid = 0; end
        end else begin
            if (f) begin
                m_inst = 0; m_pc4 = 0; m_valid = 0;
            end else begin
                m_inst = mem[m_pc[9:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1; m_cnt++;
            end
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        logic r, s, f, rd;
        logic [31:0] rpc;

        for (int i = 0; i < 256; i++) mem[i] = mem_val(i);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0;

        //   name        rst stl fl  rd  rpc            pc             inst          pc4           v  cnt
        add("rst0",      1,  0,  0,  0,  32'h0,         32'h64,        32'h0,        32'h0,        0, 0);
        add("rst1",      1,  0,  0,  0,  32'h0,         32'h64,        32'h0,        32'h0,        0, 0);
        add("run1",      0,  0,  0,  0,  32'h0,         32'h68,        32'h8C020000, 32'h68,       1, 1);
        add("run2",      0,  0,  0,  0,  32'h0,         32'h6C,        32'h8C030004, 32'h6C,       1, 2);
        add("stall1",    0,  1,  0,  0,  32'h0,         32'h6C,        32'h8C030004, 32'h6C,       1, 2);
        add("stall2",    0,  1,  0,  0,  32'h0,         32'h6C,        32'h8C030004, 32'h6C,       1, 2);
        add("unstall",   0,  0,  0,  0,  32'h0,         32'h70,        mem_val(27),  32'h70,       1, 3);
        add("redir_stl", 0,  1,  0,  1,  32'h66,        32'h64,        32'h0,        32'h0,        0, 3);
        add("run3",      0,  0,  0,  0,  32'h0,         32'h68,        mem_val(25),  32'h68,       1, 4);
        add("run4",      0,  0,  0,  0,  32'h0,         32'h6C,        mem_val(26),  32'h6C,       1, 5);
        add("run5",      0,  0,  0,  0,  32'h0,         32'h70,        mem_val(27),  32'h70,       1, 6);
        add("flush",     0,  0,  1,  0,  32'h0,         32'h74,        32'h0,        32'h0,        0, 6);
        add("run6",      0,  0,  0,  0,  32'h0,         32'h78,        mem_val(29),  32'h78,       1, 7);
        add("flush_stl", 0,  1,  1,  0,  32'h0,         32'h78,        32'h0,        32'h0,        0, 7);
        add("redir_top", 0,  0,  0,  1,  32'hFFFFFFFC,  32'hFFFFFFFC,  32'h0,        32'h0,        0, 7);
        add("wrap",      0,  0,  0,  0,  32'h0,         32'h0,         mem_val(255), 32'h0,        1, 8);
        add("redir_fl",  0,  0,  1,  1,  32'h123,       32'h120,       32'h0,        32'h0,        0, 8);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].rpc);
            chk_all(tbl[i].name, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_pc4, tbl[i].e_valid, tbl[i].e_cnt);
        end

        // Saturation: 20 fetches after reset pin the 4-bit counter at 4'hF
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0);
        chk_all("sat20", 32'h64 + 32'd80, mem_val(25 + 19), 32'h64 + 32'd80, 1, 20);
        chk("sat20.cnt4_f", {28'd0, cnt_b}, 32'hF);

        // Reset asserted mid-stall overrides stall, flush and redirect
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 32'h400);
        chk_all("rst_stall", 32'h64, 32'h0, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk_all("post_rst", 32'h68, mem_val(25), 32'h68, 1, 1);

        // Random traffic against the model
        drive(1, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            drive(r, s, f, rd, rpc);
            model_step(r, s, f, rd, rpc);
            chk_all("rand", m_pc, m_inst, m_pc4, m_valid, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
